channel_cmplx_upmix: RTL
========================

Name: channel_cmplx_upmix

Overview:
- Transmit-side counterpart of the correlator channel complex mixer, used in the imitator signal path.
- Generates the carrier from a phase accumulator and a cos/sin table, and modulates it with a ±1 code chip and an amplitude.
- Produces complex IF samples (re = cos, im = sin) for the imitator summing stage.
- Exposes the current table phase address so correlator-side checks can align to it.

Parameters:
- ACC_W, 32, phase accumulator width.
- ADDR_W, 5, table address width (2^ADDR_W entries per carrier cycle).
- TABLE_W, 8, signed table sample width.
- AMP_W, 8, unsigned amplitude width.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- en  in  1  sample enable; accumulator advances and a sample enters the pipeline only when high
- phase_step  in  ACC_W  carrier phase increment, unsigned
- phase_step_wr  in  1  one-cycle strobe; captures phase_step into the pending register
- epoch  in  1  one-cycle strobe; applies the pending step
- step_pending  out  1  pending step captured but not yet applied
- code_bit  in  1  0 → +1, 1 → −1; sampled with en
- ampl  in  AMP_W  amplitude; sampled with en
- phase_addr  out  ADDR_W  accumulator top ADDR_W bits, registered
- out_re  out  TABLE_W+AMP_W  signed cos product
- out_im  out  TABLE_W+AMP_W  signed sin product
- out_valid  out  1  out_re/out_im valid this cycle

Behaviour:
- Reset values: accumulator, active step, pending step, step_pending, phase_addr, out_re, out_im, out_valid, all pipeline registers = 0.
- Active step is 0 until the first epoch that finds a pending value.
- Step handshake:
  - phase_step_wr loads the pending register and sets step_pending.
  - epoch with step_pending = 1 copies pending to active and clears step_pending; the new step applies from the next accumulation.
  - epoch with step_pending = 0 does nothing.
  - phase_step_wr while pending overwrites the pending register (last write wins).
  - phase_step_wr and epoch in the same cycle: the new phase_step goes directly to active, step_pending ends 0.
- Accumulator:
  - On en: acc ← acc + active_step, modulo 2^ACC_W (natural wrap, no saturation).
  - Otherwise acc holds.
- Pipeline, 3 stages, each advanced every cycle with a valid bit:
  - S1: on en, register phase_addr ← acc[ACC_W-1 : ACC_W-ADDR_W] (pre-increment value), code_bit, ampl; v1 ← en.
  - S2: table lookup.
    - cos[k] = round((2^(TABLE_W-1)−1)·cos(2πk/2^ADDR_W)).
    - sin[k] = round((2^(TABLE_W-1)−1)·sin(2πk/2^ADDR_W)).
    - Quarter-wave symmetry allowed; results must match the full table exactly.
    - v2 ← v1.
  - S3: out_re ← ±(cos·ampl), out_im ← ±(sin·ampl), signed × zero-extended unsigned, negated when code_bit = 1; out_valid ← v2.
- Latency: en high in cycle n → out_valid high in cycle n+3 carrying the phase_addr captured at n.
- When out_valid = 0, out_re/out_im hold their last value.
- Full-scale products cannot overflow TABLE_W+AMP_W, since |table| ≤ 2^(TABLE_W-1)−1.
- Negation of the maximum product is exact.
- Reset mid-operation clears everything, including in-flight pipeline samples and the pending step; no output pulse follows reset release until en is asserted.

Optional Feature:
- Macro: UPMIX_PHASE_DITHER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) advances on each en.
  - The table address is taken from acc + (lfsr zero-extended and shifted so its MSB sits just below the address LSB), truncated to ADDR_W.
  - The accumulator itself is unaffected.
- Not defined: pure truncation as above.
- Latency is identical in both builds.

Test Plan:
- Reset then en = 1, no step written → phase_addr 0 every sample; out_re = 127·ampl and out_im = 0 from cycle 3; with ampl = 1: 127 / 0.
- phase_step_wr 0x08000000, epoch, en continuous, ampl = 1 → phase_addr 0,1,2,…,31,0 (wrap); sample at addr 8: out_re = 0, out_im = 127.
- Step 0x40000000, ampl = 2 → addr 0,8,16,24 repeating; out_re 254,0,−254,0; out_im 0,254,0,−254.
- code_bit toggled each sample, addr fixed at 0, ampl = 255 → out_re alternates 32385 / −32385; out_valid exactly 3 cycles after each en.
- Two phase_step_wr (0x10000000, then 0x20000000) before epoch → step_pending = 1 until epoch; 0x20000000 applied; simultaneous wr + epoch → applied immediately, step_pending = 0.
- en pulsed 1-0-1 then reset asserted mid-pipeline → out_valid never asserts for the flushed samples; all outputs read 0 during reset.

Source files
------------

// File: rtl/channel_cmplx_upmix.sv
//------------------------------------------------------------------------------
// channel_cmplx_upmix : carrier NCO with cos/sin table, +/-1 chip and amplitude
// modulation; complex IF samples for the imitator summing stage.
// Optional macro: UPMIX_PHASE_DITHER_EN (LFSR phase dither on the table address)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module channel_cmplx_upmix #(
  parameter int ACC_W   = 32,
  parameter int ADDR_W  = 5,
  parameter int TABLE_W = 8,
  parameter int AMP_W   = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en,
  input  logic [ACC_W-1:0]                 phase_step,
  input  logic                             phase_step_wr,
  input  logic                             epoch,
  output logic                             step_pending,
  input  logic                             code_bit,
  input  logic [AMP_W-1:0]                 ampl,
  output logic [ADDR_W-1:0]                phase_addr,
  output logic signed [TABLE_W+AMP_W-1:0]  out_re,
  output logic signed [TABLE_W+AMP_W-1:0]  out_im,
  output logic                             out_valid
);

  localparam int     N    = 1 << ADDR_W;
  localparam int     OW   = TABLE_W + AMP_W;
  localparam longint AMAX = (64'sd1 <<< (TABLE_W - 1)) - 64'sd1;

  // round(AMAX * sin(2*pi*k/N)) using a Q30 Taylor series on the first
  // quadrant and folding the other three quadrants by symmetry.
  function automatic logic signed [TABLE_W-1:0] tab_sin(input int k);
    longint one, x, ts, tc, s, c, v, d;
    int     n4, q, r;
    begin
      one = 64'sd1 <<< 30;
      n4  = N / 4;
      q   = (k / n4) % 4;
      r   = k % n4;
      x   = (64'sd6746518852 * longint'(r)) / longint'(N);
      s   = x;
      c   = one;
      ts  = x;
      tc  = one;
      for (int i = 1; i <= 12; i++) begin
        d  = longint'(2 * i);
        tc = -((((tc * x) >>> 30) * x) >>> 30) / ((d - 64'sd1) * d);
        ts = -((((ts * x) >>> 30) * x) >>> 30) / (d * (d + 64'sd1));
        c  = c + tc;
        s  = s + ts;
      end
      v = q[0] ? c : s;
      v = (v * AMAX + (64'sd1 <<< 29)) >>> 30;
      if (q >= 2) v = -v;
      return v[TABLE_W-1:0];
    end
  endfunction

  logic signed [TABLE_W-1:0] cos_tab [N];
  logic signed [TABLE_W-1:0] sin_tab [N];

  generate
    for (genvar k = 0; k < N; k++) begin : g_table
      localparam logic signed [TABLE_W-1:0] COS_K = tab_sin(k + N / 4);
      localparam logic signed [TABLE_W-1:0] SIN_K = tab_sin(k);
      assign cos_tab[k] = COS_K;
      assign sin_tab[k] = SIN_K;
    end
  endgenerate

  // Step handshake: pending register, applied to the active step on epoch.
  logic [ACC_W-1:0] pending_step;
  logic [ACC_W-1:0] active_step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_step <= '0;
      active_step  <= '0;
      step_pending <= 1'b0;
    end else if (phase_step_wr && epoch) begin
      pending_step <= phase_step;
      active_step  <= phase_step;
      step_pending <= 1'b0;
    end else if (phase_step_wr) begin
      pending_step <= phase_step;
      step_pending <= 1'b1;
    end else if (epoch && step_pending) begin
      active_step  <= pending_step;
      step_pending <= 1'b0;
    end
  end

  logic [ACC_W-1:0] acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   acc <= '0;
    else if (en) acc <= acc + active_step;
  end

  logic [ADDR_W-1:0] addr_next;

`ifdef UPMIX_PHASE_DITHER_EN
  localparam int SH = ACC_W - ADDR_W - 16;

  logic [15:0]       lfsr;
  logic [15:0]       acc_mid;
  logic              dith_carry;
  logic [ADDR_W-1:0] acc_top;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   lfsr <= 16'hACE1;
    else if (en) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // The dither word only occupies the 16 bits just below the address, so the
  // address is the accumulator top plus the carry out of that 16-bit field.
  assign acc_mid    = acc[ACC_W-ADDR_W-1:SH];
  assign acc_top    = acc[ACC_W-1:ACC_W-ADDR_W];
  assign dith_carry = (acc_mid > ~lfsr);
  assign addr_next  = acc_top + {{(ADDR_W-1){1'b0}}, dith_carry};
`else
  assign addr_next  = acc[ACC_W-1:ACC_W-ADDR_W];
`endif

  // S1: capture address, chip and amplitude.
  logic             code1;
  logic [AMP_W-1:0] ampl1;
  logic             v1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_addr <= '0;
      code1      <= 1'b0;
      ampl1      <= '0;
      v1         <= 1'b0;
    end else begin
      v1 <= en;
      if (en) begin
        phase_addr <= addr_next;
        code1      <= code_bit;
        ampl1      <= ampl;
      end
    end
  end

  // S2: table lookup.
  logic signed [TABLE_W-1:0] cos2;
  logic signed [TABLE_W-1:0] sin2;
  logic                      code2;
  logic [AMP_W-1:0]          ampl2;
  logic                      v2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cos2  <= '0;
      sin2  <= '0;
      code2 <= 1'b0;
      ampl2 <= '0;
      v2    <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        cos2  <= cos_tab[phase_addr];
        sin2  <= sin_tab[phase_addr];
        code2 <= code1;
        ampl2 <= ampl1;
      end
    end
  end

  // S3: the true product always fits OW bits, so an OW-bit multiply is exact.
  logic signed [OW-1:0] cos_x;
  logic signed [OW-1:0] sin_x;
  logic signed [OW-1:0] amp_x;
  logic signed [OW-1:0] prod_re;
  logic signed [OW-1:0] prod_im;

  assign cos_x   = {{AMP_W{cos2[TABLE_W-1]}}, cos2};
  assign sin_x   = {{AMP_W{sin2[TABLE_W-1]}}, sin2};
  assign amp_x   = {{TABLE_W{1'b0}}, ampl2};
  assign prod_re = cos_x * amp_x;
  assign prod_im = sin_x * amp_x;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_re    <= '0;
      out_im    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        out_re <= code2 ? -prod_re : prod_re;
        out_im <= code2 ? -prod_im : prod_im;
      end
    end
  end

endmodule

`default_nettype wire
